// File: rtl/kernel_loader.sv
// Write sequencer for the 32-unit kernel coefficient store: unit-fastest stream ordering, one-hot enables.
// Optional running checksum of accepted coefficients is enabled by defining KERNEL_LOADER_CHECKSUM_EN.
module kernel_loader #(
    parameter int WIDTH    = 16,
    parameter int NUM_COEF = 18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    coef_in,
    input  logic                coef_valid,
    output logic                coef_ready,
    output logic [4:0]          KERNEL_write_addr,
    output logic [WIDTH-1:0]    KERNEL_din,
    output logic [31:0]         KERNEL_we,
    output logic                busy,
    output logic                done,
    output logic [WIDTH+9:0]    checksum
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    localparam logic [4:0] LAST_ADDR = 5'(NUM_COEF - 1);

    state_t     state;
    logic [4:0] unit_cnt;
    logic [4:0] addr_cnt;
    logic       accept;

    assign accept = (state == LOAD) && coef_valid && coef_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            unit_cnt          <= '0;
            addr_cnt          <= '0;
            coef_ready        <= 1'b0;
            KERNEL_we         <= '0;
            KERNEL_write_addr <= '0;
            KERNEL_din        <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            KERNEL_we <= '0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        unit_cnt   <= '0;
                        addr_cnt   <= '0;
                        coef_ready <= 1'b1;
                        busy       <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        KERNEL_we         <= 32'(1) << unit_cnt;
                        KERNEL_write_addr <= addr_cnt;
                        KERNEL_din        <= coef_in;
                        unit_cnt          <= unit_cnt + 5'd1;
                        // Unit counter wraps 31->0 naturally; the address steps on that wrap.
                        if (unit_cnt == 5'd31) begin
                            addr_cnt <= addr_cnt + 5'd1;
                            if (addr_cnt == LAST_ADDR) begin
                                coef_ready <= 1'b0;
                                state      <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KERNEL_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + {{10{1'b0}}, coef_in};
        end
    end
`else
    assign checksum = '0;
`endif

endmodule
